// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiply/divide op encodings, sequencer states and default width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_addsub.sv
// WIDTH+1-bit adder/subtractor shared by the multiply and divide steps.
// o_co is the carry out when adding and the borrow out when subtracting.
module muldiv_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] i_a,
  input  logic [WIDTH:0] i_b,
  input  logic           i_sub,
  output logic [WIDTH:0] o_sum,
  output logic           o_co
);

  logic [WIDTH:0]   w_b_eff;
  logic [WIDTH+1:0] w_full;

  assign w_b_eff = i_sub ? ~i_b : i_b;
  assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{(WIDTH+1){1'b0}}, i_sub};
  assign o_sum   = w_full[WIDTH:0];
  assign o_co    = i_sub ? ~w_full[WIDTH+1] : w_full[WIDTH+1];

endmodule

// File: rtl/alu_muldiv_seq.sv
// Sequential MIPS MULT/MULTU/DIV/DIVU unit: one shift-add / restoring step per cycle.
// Optional MULDIV_EARLY_EXIT_EN ends multiplies once the remaining multiplier bits are zero.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  muldiv_state_t    r_state;
  logic [1:0]       r_op;
  logic             r_sa, r_sb, r_dbz, r_done;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hw, r_lw, r_bw, r_hi, r_lo;

  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic             w_sa, w_sb, w_b_zero, w_co, w_last;
  logic [WIDTH:0]   w_add_a, w_add_b, w_sum;
  logic [WIDTH-1:0] w_hw_nxt, w_lw_nxt, w_quot, w_rem;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;

  assign w_sa     = ~op[0] & a[WIDTH-1];
  assign w_sb     = ~op[0] & b[WIDTH-1];
  assign w_b_zero = (b == '0);

  // Divide feeds {rem, next dividend bit} - divisor; multiply feeds acc + (lsb ? mcand : 0).
  assign w_add_a = r_op[1] ? {r_hw, r_lw[WIDTH-1]} : {1'b0, r_hw};
  assign w_add_b = (r_op[1] || r_lw[0]) ? {1'b0, r_bw} : '0;

  muldiv_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_sub (r_op[1]),
    .o_sum (w_sum),
    .o_co  (w_co)
  );

  always_comb begin
    w_hw_nxt = w_sum[WIDTH:1];
    w_lw_nxt = {w_sum[0], r_lw[WIDTH-1:1]};
    if (r_op[1]) begin
      w_hw_nxt = w_co ? w_add_a[WIDTH-1:0] : w_sum[WIDTH-1:0];
      w_lw_nxt = {r_lw[WIDTH-2:0], ~w_co};
    end
  end

`ifdef MULDIV_EARLY_EXIT_EN
  logic [WIDTH-1:0] w_mask;
  assign w_mask = {WIDTH{1'b1}} >> (r_cnt + 1'b1);
  assign w_last = (r_cnt == CW'(WIDTH - 1)) || (!r_op[1] && ((w_lw_nxt & w_mask) == '0));
  // Early exit leaves the product (WIDTH - steps) bits too far left.
  assign w_prod = {r_hw, r_lw} >> (WIDTH - int'(r_cnt));
`else
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_prod = {r_hw, r_lw};
`endif

  assign w_prod_s = (r_op == OP_MULT && (r_sa ^ r_sb)) ? (~w_prod + 1'b1) : w_prod;
  assign w_quot   = (r_op == OP_DIV && (r_sa ^ r_sb)) ? (~r_lw + 1'b1) : r_lw;
  assign w_rem    = (r_op == OP_DIV && r_sa) ? (~r_hw + 1'b1) : r_hw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= OP_MULT;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_dbz   <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_hw    <= '0;
      r_lw    <= '0;
      r_bw    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_op    <= op;
          r_sa    <= w_sa;
          r_sb    <= w_sb;
          r_dbz   <= op[1] & w_b_zero;
          r_cnt   <= '0;
          r_hw    <= '0;
          r_bw    <= op[1] ? f_mag(b, w_sb) : f_mag(a, w_sa);
          // Divide-by-zero keeps the raw dividend so HI can return it untouched.
          r_lw    <= (op[1] && w_b_zero) ? a : (op[1] ? f_mag(a, w_sa) : f_mag(b, w_sb));
          r_state <= (op[1] && w_b_zero) ? FIX : RUN;
        end
        RUN: begin
          r_hw  <= w_hw_nxt;
          r_lw  <= w_lw_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= FIX;
        end
        FIX: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
          if (r_dbz) begin
            r_hi <= r_lw;
            r_lo <= '1;
          end else if (r_op[1]) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            {r_hi, r_lo} <= w_prod_s;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
